// File: rtl/fwd_sel_unit_pkg.sv
// fwd_pkg: shared constants and types for the EX-stage operand forwarding
// select unit (fwd_sel_unit) and its per-operand comparator (fwd_match).
// Optional build macro LOAD_FWD_MEM2_EN is consumed by fwd_match.
package fwd_pkg;

    // Issue width; the select encoding below assumes exactly four lanes.
    localparam int NLANE  = 4;
    localparam int LANE_W = 2;

    // Shadow destination field is wide enough for any REGW up to 8.
    localparam int SH_DSTW = 8;

    typedef logic [3:0] sel_t;

    localparam sel_t SEL_RF        = 4'd0;
    localparam sel_t SEL_MEM1_BASE = 4'd1;
    localparam sel_t SEL_MEM2_BASE = 4'd5;
    localparam sel_t SEL_WB_BASE   = 4'd9;

    typedef struct packed {
        logic [SH_DSTW-1:0] dst;
        logic               regwrite;
        logic               load;
    } shadow_entry_t;

    localparam shadow_entry_t SH_EMPTY = '{dst: 8'd0, regwrite: 1'b0, load: 1'b0};

    // Index of the highest set lane bit (later lane in program order).
    function automatic logic [LANE_W-1:0] hi_lane(input logic [NLANE-1:0] v);
        logic [LANE_W-1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NLANE; i++) begin
            if (v[i]) begin
                idx = LANE_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fwd_sel_unit_match.sv
// fwd_match: priority comparator for one IS-stage source operand against the
// EX / MEM1 / MEM2 shadow ranks. Youngest rank wins, then highest lane.
// Build macro LOAD_FWD_MEM2_EN: when defined, a load found in MEM1 is
// forwardable and does not raise load_hit; otherwise it does.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int REGW = 5
) (
    input  logic [REGW-1:0]             src,
    input  shadow_entry_t [NLANE-1:0]   sh_ex,
    input  shadow_entry_t [NLANE-1:0]   sh_mem1,
    input  shadow_entry_t [NLANE-1:0]   sh_mem2,
    output sel_t                        sel,
    output logic                        load_hit
);

    logic [SH_DSTW-1:0] src_ext_s;
    logic               src_nz_s;
    logic [NLANE-1:0]   hit_ex_s;
    logic [NLANE-1:0]   hit_mem1_s;
    logic [NLANE-1:0]   hit_mem2_s;
    logic [LANE_W-1:0]  lane_s;
    sel_t               sel_s;
    logic               load_hit_s;
    logic               unused_load_s;

    assign src_ext_s = SH_DSTW'(src);
    assign src_nz_s  = (src != {REGW{1'b0}});

    // Per-lane destination hits in each rank; register $0 never matches.
    always_comb begin
        for (int l = 0; l < NLANE; l++) begin
            hit_ex_s[l]   = src_nz_s && sh_ex[l].regwrite   && (sh_ex[l].dst   == src_ext_s);
            hit_mem1_s[l] = src_nz_s && sh_mem1[l].regwrite && (sh_mem1[l].dst == src_ext_s);
            hit_mem2_s[l] = src_nz_s && sh_mem2[l].regwrite && (sh_mem2[l].dst == src_ext_s);
        end
    end

    // Pick the youngest rank, then the highest lane; flag loads not yet forwardable.
    always_comb begin
        sel_s      = SEL_RF;
        load_hit_s = 1'b0;
        lane_s     = 2'd0;
        if (|hit_ex_s) begin
            lane_s     = hi_lane(hit_ex_s);
            sel_s      = SEL_MEM1_BASE + sel_t'(lane_s);
            load_hit_s = sh_ex[lane_s].load;
        end else if (|hit_mem1_s) begin
            lane_s     = hi_lane(hit_mem1_s);
            sel_s      = SEL_MEM2_BASE + sel_t'(lane_s);
`ifdef LOAD_FWD_MEM2_EN
            load_hit_s = 1'b0;
`else
            load_hit_s = sh_mem1[lane_s].load;
`endif
        end else if (|hit_mem2_s) begin
            lane_s     = hi_lane(hit_mem2_s);
            sel_s      = SEL_WB_BASE + sel_t'(lane_s);
            load_hit_s = 1'b0;
        end else begin
            sel_s      = SEL_RF;
            load_hit_s = 1'b0;
        end
    end

    // Load flags of ranks whose data is always forwardable are not consulted.
    always_comb begin
        unused_load_s = 1'b0;
        for (int l = 0; l < NLANE; l++) begin
            unused_load_s = unused_load_s ^ sh_mem2[l].load ^ sh_mem1[l].load;
        end
    end

    assign sel      = sel_s;
    assign load_hit = load_hit_s;

endmodule

// File: rtl/fwd_sel_unit.sv
// fwd_sel_unit: EX-stage operand select generation for the 7-stage, 4-issue
// pipeline. Tracks EX/MEM1/MEM2 destinations in shadow ranks, registers one
// select code per EX operand mux, and raises a combinational load-use stall.
// Build macro LOAD_FWD_MEM2_EN (see fwd_match) widens load forwarding to MEM2.
module fwd_sel_unit #(
    parameter int REGW  = 5,
    parameter int NLANE = fwd_pkg::NLANE
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NLANE-1:0]                  is_valid_i,
    input  logic [2*NLANE-1:0][REGW-1:0]      is_src_i,
    input  logic [NLANE-1:0][REGW-1:0]        is_dst_i,
    input  logic [NLANE-1:0]                  is_regwrite_i,
    input  logic [NLANE-1:0]                  is_load_i,
    input  logic                              hold_i,
    input  logic                              flush_i,
    output logic [2*NLANE-1:0][3:0]           sel_o,
    output logic                              load_stall_o
);
    import fwd_pkg::sel_t;
    import fwd_pkg::shadow_entry_t;
    import fwd_pkg::SH_EMPTY;
    import fwd_pkg::SEL_RF;
    import fwd_pkg::SH_DSTW;

    shadow_entry_t [NLANE-1:0] sh_ex_r;
    shadow_entry_t [NLANE-1:0] sh_mem1_r;
    shadow_entry_t [NLANE-1:0] sh_mem2_r;
    sel_t [2*NLANE-1:0]        sel_r;

    shadow_entry_t [NLANE-1:0] is_entry_s;
    sel_t [2*NLANE-1:0]        match_sel_s;
    logic [2*NLANE-1:0]        load_hit_s;
    logic [2*NLANE-1:0]        opnd_valid_s;
    logic                      load_stall_s;
    logic                      advance_s;
    logic                      bubble_s;

    // IS bundle as it will enter the EX shadow rank; invalid lanes never write.
    always_comb begin
        for (int l = 0; l < NLANE; l++) begin
            is_entry_s[l].dst      = SH_DSTW'(is_dst_i[l]);
            is_entry_s[l].regwrite = is_regwrite_i[l] & is_valid_i[l];
            is_entry_s[l].load     = is_load_i[l];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2*NLANE; gi++) begin : g_match
            fwd_match #(.REGW(REGW)) u_match (
                .src      (is_src_i[gi]),
                .sh_ex    (sh_ex_r),
                .sh_mem1  (sh_mem1_r),
                .sh_mem2  (sh_mem2_r),
                .sel      (match_sel_s[gi]),
                .load_hit (load_hit_s[gi])
            );
        end
    endgenerate

    // Operand k of lane l is only meaningful when lane l is valid.
    always_comb begin
        for (int i = 0; i < 2*NLANE; i++) begin
            opnd_valid_s[i] = is_valid_i[i/2];
        end
    end

    // Stall, advance and bubble decisions in edge-priority order: flush, hold, stall.
    always_comb begin
        load_stall_s = |(load_hit_s & opnd_valid_s);
        advance_s    = flush_i | ~hold_i;
        bubble_s     = flush_i | (~hold_i & load_stall_s);
    end

    // Shadow ranks and registered select codes.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_ex_r   <= {NLANE{SH_EMPTY}};
            sh_mem1_r <= {NLANE{SH_EMPTY}};
            sh_mem2_r <= {NLANE{SH_EMPTY}};
            sel_r     <= {(2*NLANE){SEL_RF}};
        end else if (advance_s) begin
            sh_mem2_r <= sh_mem1_r;
            sh_mem1_r <= sh_ex_r;
            if (bubble_s) begin
                sh_ex_r <= {NLANE{SH_EMPTY}};
                sel_r   <= {(2*NLANE){SEL_RF}};
            end else begin
                sh_ex_r <= is_entry_s;
                sel_r   <= match_sel_s;
            end
        end else begin
            sh_ex_r   <= sh_ex_r;
            sh_mem1_r <= sh_mem1_r;
            sh_mem2_r <= sh_mem2_r;
            sel_r     <= sel_r;
        end
    end

    assign sel_o        = sel_r;
    assign load_stall_o = reset ? 1'b0 : load_stall_s;

endmodule

// File: tb/tb_fwd_sel_unit.sv
// Scoreboard bench for fwd_sel_unit: the stimulus process drives one IS bundle
// per cycle and queues the expected sel_o / load_stall_o for that cycle; a
// separate monitor pops and compares on the falling edge.
module tb_fwd_sel_unit;

    localparam int REGW  = 5;
    localparam int NLANE = 4;

    logic                         clk;
    logic                         reset;
    logic [NLANE-1:0]             is_valid;
    logic [2*NLANE-1:0][REGW-1:0] is_src;
    logic [NLANE-1:0][REGW-1:0]   is_dst;
    logic [NLANE-1:0]             is_regwrite;
    logic [NLANE-1:0]             is_load;
    logic                         hold;
    logic                         flush;
    logic [2*NLANE-1:0][3:0]      sel;
    logic                         load_stall;

    fwd_sel_unit #(.REGW(REGW), .NLANE(NLANE)) dut (
        .clk           (clk),
        .reset         (reset),
        .is_valid_i    (is_valid),
        .is_src_i      (is_src),
        .is_dst_i      (is_dst),
        .is_regwrite_i (is_regwrite),
        .is_load_i     (is_load),
        .hold_i        (hold),
        .flush_i       (flush),
        .sel_o         (sel),
        .load_stall_o  (load_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sel;
        logic        stall;
        int          step;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   step_n = 0;

    // Monitor: compare the DUT against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_chk++;
            if (sel === e.sel) n_pass++;
            else $display("FAIL sel step %0d: got %08h want %08h", e.step, sel, e.sel);
            n_chk++;
            if (load_stall === e.stall) n_pass++;
            else $display("FAIL load_stall step %0d: got %0b want %0b", e.step, load_stall, e.stall);
        end
    end

    task automatic clr();
        is_valid    = 4'd0;
        is_src      = 40'd0;
        is_dst      = 20'd0;
        is_regwrite = 4'd0;
        is_load     = 4'd0;
        hold        = 1'b0;
        flush       = 1'b0;
    endtask

    // Queue expectations for the cycle whose inputs are now applied, then advance.
    task automatic chk(input logic [31:0] es, input logic est);
        exp_t e;
        e.sel   = es;
        e.stall = est;
        e.step  = step_n;
        exp_q.push_back(e);
        step_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic writer(input int lane, input logic [4:0] rd, input logic ld);
        is_valid[lane]    = 1'b1;
        is_dst[lane]      = rd;
        is_regwrite[lane] = 1'b1;
        is_load[lane]     = ld;
    endtask

    task automatic reader(input int opnd, input logic [4:0] rs);
        is_valid[opnd/2] = 1'b1;
        is_src[opnd]     = rs;
    endtask

    task automatic drain();
        clr();
        for (int i = 0; i < 3; i++) chk(32'h0, 1'b0);
    endtask

    initial begin
        clr();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk(32'h0, 1'b0);                 // reset state
        reset = 1'b0;
        chk(32'h0, 1'b0);

        // Lane 2 writes r5, next bundle lane 0 reads r5 -> MEM1 lane 2 = 3.
        clr(); writer(2, 5'd5, 1'b0); chk(32'h0, 1'b0);
        clr(); reader(0, 5'd5);       chk(32'h0, 1'b0);
        clr();                        chk(32'h0000_0003, 1'b0);
        drain();

        // r7 by lane 1 then lane 3; younger rank wins -> 4 on operands 0 and 5.
        clr(); writer(1, 5'd7, 1'b0); chk(32'h0, 1'b0);
        clr(); writer(3, 5'd7, 1'b0); chk(32'h0, 1'b0);
        clr(); reader(0, 5'd7); reader(5, 5'd7); chk(32'h0, 1'b0);
        clr();                        chk(32'h0040_0004, 1'b0);
        drain();

        // Load-use: lane 0 loads r9, operand 3 reads r9.
        clr(); writer(0, 5'd9, 1'b1); chk(32'h0, 1'b0);
        clr(); reader(3, 5'd9);       chk(32'h0, 1'b1);
`ifdef LOAD_FWD_MEM2_EN
        chk(32'h0, 1'b0);
        clr();                        chk(32'h0000_5000, 1'b0);
`else
        chk(32'h0, 1'b1);
        chk(32'h0, 1'b0);
        clr();                        chk(32'h0000_9000, 1'b0);
`endif
        drain();

        // r0 is never forwarded; r6 from lane 3 still is (operand 1 -> 4).
        clr(); writer(0, 5'd0, 1'b0); writer(3, 5'd6, 1'b0); chk(32'h0, 1'b0);
        clr(); reader(0, 5'd0); reader(1, 5'd6); reader(2, 5'd0); chk(32'h0, 1'b0);
        clr();                        chk(32'h0000_0040, 1'b0);
        drain();

        // Flushed writer of r3 must never be matched.
        clr(); writer(1, 5'd3, 1'b0); flush = 1'b1; chk(32'h0, 1'b0);
        clr(); reader(0, 5'd3);       chk(32'h0, 1'b0);
        clr();                        chk(32'h0, 1'b0);
        drain();

        // Hold freezes the ranks: r4 from lane 0 still matches afterwards -> 1.
        clr(); writer(0, 5'd4, 1'b0); chk(32'h0, 1'b0);
        clr(); reader(0, 5'd4); hold = 1'b1; chk(32'h0, 1'b0);
        hold = 1'b0;                  chk(32'h0, 1'b0);
        clr();                        chk(32'h0000_0001, 1'b0);
        drain();

        // Hold together with a load stall: nothing moves until hold drops.
        clr(); writer(3, 5'd11, 1'b1); chk(32'h0, 1'b0);
        clr(); reader(0, 5'd11); hold = 1'b1; chk(32'h0, 1'b1);
        hold = 1'b0;                  chk(32'h0, 1'b1);
`ifdef LOAD_FWD_MEM2_EN
        chk(32'h0, 1'b0);
        clr();                        chk(32'h0000_0008, 1'b0);
`else
        chk(32'h0, 1'b1);
        chk(32'h0, 1'b0);
        clr();                        chk(32'h0000_000C, 1'b0);
`endif
        drain();

        // Reset mid-stall clears the stall and the load producer.
        clr(); writer(0, 5'd9, 1'b1); chk(32'h0, 1'b0);
        clr(); reader(3, 5'd9);       chk(32'h0, 1'b1);
        reset = 1'b1;                 chk(32'h0, 1'b0);
        reset = 1'b0;                 chk(32'h0, 1'b0);
        clr();                        chk(32'h0, 1'b0);

        @(negedge clk);
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fwd_sel_unit.md
# fwd_sel_unit

- Generates the 4-bit select code for each of the 8 EX-stage operand muxes (4 issue lanes × 2 sources) in the 7-stage, 4-issue pipeline.
- Pipeline stages: IF, ID, IS, EX, MEM1, MEM2, WB.
- Keeps a shadow copy of destination-register, write-enable and load information for the bundles in EX, MEM1 and MEM2.
- Compares each IS-stage source register against the shadow copies and registers the select code so it lines up with the bundle when that bundle enters EX.
- Raises a load-use stall when a source depends on a load result that is not yet available.

## Interface
Parameters
- `REGW`, default 5: register-address width.
- `NLANE`, default 4: issue lanes. Fixed at 4, because the select encoding depends on it.

Ports
- `clk` input 1: clock. One clock domain.
- `reset` input 1: synchronous, active-high reset.
- `is_valid_i` input [NLANE-1:0]: IS-stage lane holds a real instruction.
- `is_src_i` input [2*NLANE-1:0][REGW-1:0]: source register for operand k of lane l, at index 2l+k.
- `is_dst_i` input [NLANE-1:0][REGW-1:0]: destination register of each IS lane.
- `is_regwrite_i` input [NLANE-1:0]: IS lane writes `is_dst_i`.
- `is_load_i` input [NLANE-1:0]: IS lane is a load.
- `hold_i` input 1: external pipeline freeze.
- `flush_i` input 1: kill the bundle entering EX.
- `sel_o` output [2*NLANE-1:0][3:0]: registered select code for each EX operand mux.
- `load_stall_o` output 1: combinational. Requests that the IS bundle be held one cycle.

## Operation
Select codes
- 0: register file.
- 1–4: MEM1 lanes 0–3.
- 5–8: MEM2 lanes 0–3.
- 9–12: WB lanes 0–3.
- 13–15: never produced.

State
- Three shadow ranks: SH_EX, SH_MEM1, SH_MEM2.
- Each rank holds per lane: `dst`, `regwrite`, `load`.
- On every advance: SH_MEM2 ← SH_MEM1, SH_MEM1 ← SH_EX, SH_EX ← the IS bundle, with `regwrite` masked by `is_valid_i`.

Matching, per operand
- A source of 0 (register $0) always gives code 0.
- A match against SH_EX gives MEM1 codes; SH_MEM1 gives MEM2 codes; SH_MEM2 gives WB codes.
- The youngest rank wins: SH_EX over SH_MEM1 over SH_MEM2.
- Within a rank, the highest lane index wins (later in program order).
- Matches within the same IS bundle are ignored. Intra-bundle dependences are excluded by the issue logic.
- No match gives code 0.

Load-use stall
- `load_stall_o` = 1 when any valid operand's winning match is a load in SH_EX (its data is not available in MEM1).
- While stalled: SH_EX takes a bubble (all `regwrite` = 0), and `sel_o` takes all-zero.
- The older shadow ranks still advance.

Register-file coverage
- Producers that retire out of WB before the consumer reaches EX are served by the write-through register file (code 0).

Update priority at each rising edge
- `reset`: all ranks cleared, `sel_o` = 0.
- `flush_i`: SH_EX bubble, `sel_o` = 0, older ranks advance.
- `hold_i`: every register holds.
- Stall: as described above.
- Otherwise: normal advance.

## Timing
- `sel_o` is valid one cycle after the IS inputs, i.e. in the same cycle the bundle occupies EX.
- `load_stall_o` has zero latency and comes only from flops and IS inputs. It is forced to 0 while `reset` is high.
- Reset value of every output is 0. Reset mid-stall clears the stall on the next cycle.
- A load followed by a dependent instruction in the next bundle: exactly one stall cycle, then a MEM2 code (5–8).
- `hold_i` together with a stall: hold wins and nothing changes. The stall is re-evaluated once `hold_i` drops.

## Configuration
- `LOAD_FWD_MEM2_EN` defined: load results are forwardable from MEM2 and WB. Stall only when the load is in SH_EX.
- `LOAD_FWD_MEM2_EN` undefined: load results are forwardable from WB only.
  - A winning load match in SH_EX or SH_MEM1 stalls.
  - A dependent instruction in the next bundle stalls 2 cycles.
- Non-load forwarding is identical in both builds.

## Structure
- Package `fwd_pkg` holds:
  - `NLANE` and the `SEL_RF` and `SEL_MEM1_BASE` / `SEL_MEM2_BASE` / `SEL_WB_BASE` constants.
  - The `shadow_entry_t` struct (`dst`, `regwrite`, `load`).
  - The `sel_t` typedef (logic [3:0]).
- Sub-module `fwd_match`: one operand's priority comparator against the three ranks. It returns `sel_t` and a load-hit flag, and is instantiated 2·NLANE times.

## Test plan
- Lane 2 writes r5; the next bundle's lane 0 reads r5 → `sel_o[0]` = 3 in that bundle's EX cycle, `load_stall_o` = 0.
- r7 is written by lane 1 in bundle N and by lane 3 in bundle N+1; bundle N+2 reads r7 → code 4 (youngest rank, MEM1 lane 3).
- Lane 0 loads r9; the next bundle reads r9 → `load_stall_o` = 1 for 1 cycle (2 cycles without the macro), a bubble reaches EX with `sel_o` all 0, then code 5 (code 9 without the macro).
- Any lane reads r0 while a lane writes r0 → code 0.
- `flush_i` asserted with a valid writer of r3 in IS; a later bundle reads r3 → r3 is never matched from the flushed instruction (code 0).
- `reset` asserted mid-stall → next cycle `sel_o` = 0, `load_stall_o` = 0, and no prior writer matches.
